// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: tracks destinations of in-flight instructions from EX to WB and
// derives forwarding selects, load-use stalls and branch flushes from that record.
module pipe_hazard_ctrl #(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int RA_W     = 5,
    parameter int CNT_W    = 16,
    parameter int FWD_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ext_stall,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             branch_taken,
    output logic             stall,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [FWD_W-1:0] fwd_rs1,
    output logic [FWD_W-1:0] fwd_rs2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [DEPTH-1:0] vld_p;
    logic [DEPTH-1:0] regwr_p;
    logic [DEPTH-1:0] memrd_p;
    logic [RA_W-1:0]  rd_p [DEPTH];
    logic [RA_W-1:0]  rs1_p0;
    logic [RA_W-1:0]  rs2_p0;
    logic             rs1_used_p0;
    logic             rs2_used_p0;

    logic flush;
    logic load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Lowest producing stage wins; scanning from WB down lets nearer stages overwrite.
    always_comb begin
        fwd_rs1  = '0;
        fwd_rs2  = '0;
        load_use = 1'b0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (vld_p[k] && regwr_p[k] && (rd_p[k] != '0) && !((k < LOAD_LAT) && memrd_p[k])) begin
                if (vld_p[0] && rs1_used_p0 && (rd_p[k] == rs1_p0))
                    fwd_rs1 = FWD_W'(k);
                if (vld_p[0] && rs2_used_p0 && (rd_p[k] == rs2_p0))
                    fwd_rs2 = FWD_W'(k);
            end
        end
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (vld_p[k] && regwr_p[k] && memrd_p[k] && (rd_p[k] != '0) &&
                ((id_rs1_used && (id_rs1 == rd_p[k])) || (id_rs2_used && (id_rs2 == rd_p[k]))))
                load_use = 1'b1;
        end
    end

    assign flush      = branch_taken && vld_p[0] && !ext_stall;
    assign flush_ifid = flush;
    assign flush_idex = flush;
    assign stall      = id_valid && load_use && !flush;

    // Control state: valid bits and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p     <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!ext_stall) begin
            vld_p <= {vld_p[DEPTH-2:0], id_valid && !flush && !stall};
            if (stall)
                stall_cnt <= sat_inc(stall_cnt);
            if (flush)
                flush_cnt <= sat_inc(flush_cnt);
        end
    end

    // Record payload; meaningful only where the matching valid bit is set
    always_ff @(posedge clk) begin
        if (!ext_stall) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                rd_p[k] <= rd_p[k-1];
            end
            rd_p[0]     <= id_rd;
            regwr_p     <= {regwr_p[DEPTH-2:0], id_regwrite};
            memrd_p     <= {memrd_p[DEPTH-2:0], id_memread};
            rs1_p0      <= id_rs1;
            rs2_p0      <= id_rs2;
            rs1_used_p0 <= id_rs1_used;
            rs2_used_p0 <= id_rs2_used;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (DEPTH=3, LOAD_LAT=1, CNT_W=4) with a per-cycle
// scoreboard of the forwarding selects expected for whatever enters EX.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ext_stall = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       id_rs1_used = 1'b0;
    logic       id_rs2_used = 1'b0;
    logic [4:0] id_rd = '0;
    logic       id_regwrite = 1'b0;
    logic       id_memread = 1'b0;
    logic       branch_taken = 1'b0;
    logic       stall;
    logic       flush_ifid;
    logic       flush_idex;
    logic [1:0] fwd_rs1;
    logic [1:0] fwd_rs2;
    logic [3:0] stall_cnt;
    logic [3:0] flush_cnt;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        string      tag;
        logic [1:0] f1;
        logic [1:0] f2;
    } exp_t;
    exp_t sb[$];

    pipe_hazard_ctrl #(.DEPTH(3), .LOAD_LAT(1), .RA_W(5), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .ext_stall(ext_stall), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .branch_taken(branch_taken), .stall(stall), .flush_ifid(flush_ifid),
        .flush_idex(flush_idex), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_flush_ifid"}, 32'(flush_ifid), 32'd0);
        chk({tag, "_flush_idex"}, 32'(flush_idex), 32'd0);
        chk({tag, "_fwd1"}, 32'(fwd_rs1), 32'd0);
        chk({tag, "_fwd2"}, 32'(fwd_rs2), 32'd0);
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
        chk({tag, "_flush_cnt"}, 32'(flush_cnt), 32'd0);
    endtask

    // Drive one ID instruction, check this cycle's stall/flush, record what EX must see next.
    task automatic issue(input string tag, input logic v,
                         input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2,
                         input logic [4:0] rd, input logic rw, input logic mr,
                         input logic e_stall, input logic e_flush,
                         input logic [1:0] n1, input logic [1:0] n2);
        exp_t e;
        id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
        id_rd = rd; id_regwrite = rw; id_memread = mr;
        #1;
        chk({tag, "_stall"}, 32'(stall), 32'(e_stall));
        chk({tag, "_flush_ifid"}, 32'(flush_ifid), 32'(e_flush));
        chk({tag, "_flush_idex"}, 32'(flush_idex), 32'(e_flush));
        e.tag = tag; e.f1 = n1; e.f2 = n2;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk({e.tag, "_next_fwd1"}, 32'(fwd_rs1), 32'(e.f1));
        chk({e.tag, "_next_fwd2"}, 32'(fwd_rs2), 32'(e.f2));
    endtask

    task automatic bubble(input string tag);
        issue(tag, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    endtask

    initial begin
        // Reset held with ID and branch active: everything reads 0
        #1 rst = 1'b1;
        id_valid = 1'b1; branch_taken = 1'b1; id_rs1 = 5'd3; id_rs1_used = 1'b1;
        #1;
        all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        id_valid = 1'b0; branch_taken = 1'b0;
        rst = 1'b0;
        #1;
        all_zero("post_reset");
        @(posedge clk); #1;

        // ALU chain: add x5 ; sub x6,x5,x1 ; or x7,x5,x2
        issue("alu_add", 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 2'd0, 2'd0);
        issue("alu_sub", 1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0, 2'd1, 2'd0);
        issue("alu_or",  1, 5'd5, 1, 5'd2, 1, 5'd7, 1, 0, 0, 0, 2'd2, 2'd0);
        repeat (3) bubble("drain1");

        // Load-use: lw x6 ; add x7,x6,x6
        issue("lu_lw",    1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1, 0, 0, 2'd0, 2'd0);
        issue("lu_stall", 1, 5'd6, 1, 5'd6, 1, 5'd7, 1, 0, 1, 0, 2'd0, 2'd0);
        issue("lu_add",   1, 5'd6, 1, 5'd6, 1, 5'd7, 1, 0, 0, 0, 2'd2, 2'd2);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        repeat (3) bubble("drain2");

        // Taken branch while a load-use condition exists: flush wins
        issue("br_lw", 1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 1, 0, 0, 2'd0, 2'd0);
        branch_taken = 1'b1;
        issue("br_flush", 1, 5'd8, 1, 5'd0, 0, 5'd9, 1, 0, 0, 1, 2'd0, 2'd0);
        issue("br_after", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0);
        branch_taken = 1'b0;
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("br_stall_cnt", 32'(stall_cnt), 32'd1);
        repeat (3) bubble("drain3");

        // x0 destination never forwards or stalls
        issue("x0_addi", 1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 0, 0, 0, 2'd0, 2'd0);
        issue("x0_read", 1, 5'd0, 1, 5'd0, 1, 5'd10, 1, 0, 0, 0, 2'd0, 2'd0);
        issue("x0_lw",   1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0, 2'd0, 2'd0);
        issue("x0_use",  1, 5'd0, 1, 5'd0, 1, 5'd11, 1, 0, 0, 0, 2'd0, 2'd0);
        repeat (3) bubble("drain4");

        // Freeze with a pending taken branch
        issue("frz_b", 1, 5'd1, 1, 5'd0, 0, 5'd9, 1, 0, 0, 0, 2'd0, 2'd0);
        issue("frz_c", 1, 5'd9, 1, 5'd0, 0, 5'd12, 1, 0, 0, 0, 2'd1, 2'd0);
        ext_stall = 1'b1; branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue("frz_hold", 1, 5'd2, 1, 5'd0, 0, 5'd13, 1, 0, 0, 0, 2'd1, 2'd0);
            chk("frz_stall_cnt", 32'(stall_cnt), 32'd1);
            chk("frz_flush_cnt", 32'(flush_cnt), 32'd1);
        end
        ext_stall = 1'b0;
        issue("frz_release", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 2'd0, 2'd0);
        branch_taken = 1'b0;
        chk("frz_flush_cnt_after", 32'(flush_cnt), 32'd2);
        repeat (3) bubble("drain5");

        // Saturating stall counter: 17 more load-use stalls on top of the earlier one
        for (int i = 0; i < 17; i++) begin
            issue("sat_lw",    1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 1, 0, 0, 2'd0, 2'd0);
            issue("sat_stall", 1, 5'd6, 1, 5'd6, 1, 5'd7, 1, 0, 1, 0, 2'd0, 2'd0);
            issue("sat_add",   1, 5'd6, 1, 5'd6, 1, 5'd7, 1, 0, 0, 0, 2'd2, 2'd2);
            chk("sat_stall_cnt", 32'(stall_cnt), (i + 2 > 15) ? 32'd15 : 32'(i + 2));
        end
        chk("sat_final", 32'(stall_cnt), 32'd15);

        // Reset mid-stall clears everything within the same cycle
        issue("rs_lw", 1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 1, 0, 0, 2'd0, 2'd0);
        id_valid = 1'b1; id_rs1 = 5'd6; id_rs1_used = 1'b1; id_rs2 = 5'd6; id_rs2_used = 1'b1;
        id_rd = 5'd7; id_regwrite = 1'b1; id_memread = 1'b0;
        #1;
        chk("rs_pre_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        all_zero("rs_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        all_zero("rs_release");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard controller for the RISC-V core. It tracks the destination register of every in-flight instruction from EX through WB. From that record it generates three things: operand-forwarding selects for the instruction in EX, load-use stalls for the instruction in ID, and branch flushes. It replaces the fixed 3-stage forwarding and hazard logic with one block that is configurable in depth and load latency and supports an external freeze.

## Interface
- `DEPTH`, default 3: number of tracked stages after ID (stage 0 = EX, stage DEPTH-1 = WB); legal range 2..8.
- `LOAD_LAT`, default 1: number of stages, counted from EX, in which load data is not yet forwardable; legal range 1..DEPTH-1.
- `RA_W`, default 5: register address width.
- `CNT_W`, default 16: width of the performance counters.
- `FWD_W`, default `$clog2(DEPTH)`: width of the forward-select outputs (derived).

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `ext_stall`, in, 1: freezes all tracked stages (for example a memory wait).
- `id_valid`, in, 1: ID holds a real instruction.
- `id_rs1`, `id_rs2`, in, RA_W each: ID source registers.
- `id_rs1_used`, `id_rs2_used`, in, 1 each: the source is actually read.
- `id_rd`, in, RA_W: ID destination register.
- `id_regwrite`, in, 1: ID instruction writes `id_rd`.
- `id_memread`, in, 1: ID instruction is a load.
- `branch_taken`, in, 1: the EX instruction redirects the PC.
- `stall`, out, 1: hold PC and IF/ID; insert a bubble into EX.
- `flush_ifid`, out, 1: kill the IF/ID contents.
- `flush_idex`, out, 1: kill the instruction entering EX.
- `fwd_rs1`, `fwd_rs2`, out, FWD_W each: EX operand source. 0 = register file; k = result of stage k (1..DEPTH-1).
- `stall_cnt`, out, CNT_W: count of load-use stall cycles (saturating).
- `flush_cnt`, out, CNT_W: count of taken-branch flushes (saturating).

## Operation
- Each stage record holds `{valid, rd, regwrite, memread}`. Stage 0 additionally holds `{rs1, rs1_used, rs2, rs2_used}`.
- A stage k *produces* register r when `valid && regwrite && rd == r && r != 0`. Register x0 is never forwarded and never stalls.
- **Forwarding** (combinational, for the stage-0 operands):
  - `fwd_rsN` is the lowest k in 1..DEPTH-1 whose stage produces stage0.rsN, provided `rsN_used` is set and stage 0 is valid.
  - A producing stage k < LOAD_LAT that has `memread` set is skipped; this case cannot occur after a correct stall.
  - Otherwise `fwd_rsN` = 0.
- **Load-use stall** (combinational): `stall` = `id_valid` AND there exists a stage k < LOAD_LAT that produces a used ID source AND has `memread` set.
- **Flush** (combinational): `flush_ifid` = `flush_idex` = `branch_taken && stage0.valid && !ext_stall`.
- **Priority**, highest first: `rst`, then `ext_stall`, then flush, then stall, then normal advance. When flush is active, `stall` is forced to 0.
- **Update at the clock edge**:
  - `ext_stall`: all records hold; counters hold.
  - Otherwise, stage k+1 takes the contents of stage k, and stage 0 loads as follows:
    - a bubble (`valid` = 0) on flush or stall;
    - else the ID record with `valid` = `id_valid`.
  - The record leaving stage DEPTH-1 is discarded.
- **Counters**: `stall_cnt` +1 on each advancing cycle with `stall` = 1. `flush_cnt` +1 on each cycle with flush active. Both saturate at 2^CNT_W − 1.

## Timing
- Reset (asynchronous): all `valid` bits and both counters go to 0 immediately. Consequently `stall`, `flush_ifid`, `flush_idex`, `fwd_rs1` and `fwd_rs2` are all 0 while `rst` is high and in the first cycle after release.
- All outputs are combinational from the current records and inputs within the same cycle. Records update one clock edge later.
- A load-use stall lasts `LOAD_LAT − k` cycles, where k is the stage of the load; this is 1 cycle for the defaults.
- A flush is asserted for the single cycle in which the branch is in EX. The next cycle, stage 0 is a bubble.
- `branch_taken` asserted while `ext_stall` is high is ignored. It is re-evaluated when the freeze ends, because the branch is still in EX.
- Reset asserted mid-stall or mid-flush clears the record immediately; no partial update occurs.

## Test plan
- **ALU chain, defaults.** `add x5` issued, then `sub x6,x5,x1`, then `or x7,x5,x2`. Required: `sub` in EX sees `fwd_rs1` = 1; `or` in EX sees `fwd_rs1` = 2; `stall` stays 0.
- **Load-use.** `lw x6` followed by `add x7,x6,x6`. Required: `stall` = 1 for exactly 1 cycle; stage 0 is a bubble; then `add` in EX sees `fwd_rs1` = `fwd_rs2` = 2; `stall_cnt` = 1.
- **Branch taken with stage 0 valid.** Required: `flush_ifid` = `flush_idex` = 1 for 1 cycle; stage 0 invalid on the next cycle; `flush_cnt` = 1. Also, a simultaneous load-use condition yields `stall` = 0.
- **x0 destination.** `addi x0,...` followed by a reader of x0. Required: `fwd` = 0 and `stall` = 0.
- **Freeze.** `ext_stall` held high for 3 cycles with `branch_taken` = 1. Required: records, counters and `fwd` values stay constant and no flush occurs. After release, a flush occurs once.
- **Saturation and reset.** With `CNT_W` = 4, force 17 load-use stalls; `stall_cnt` must stick at 15. Assert `rst` mid-stall; all outputs must read 0 in the same cycle.
